// File: rtl/usb_tx_pkg.sv
// Shared types and constants for the USB full-speed transmit line encoder.
// Line levels are packed as {D+, D-}.
package usb_tx_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SYNC  = 3'd1,
        DATA  = 3'd2,
        EOP1  = 3'd3,
        EOP2  = 3'd4,
        EOP_J = 3'd5
    } tx_state_e;

    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'h80;
    localparam int         STUFF_LEN_DEF = 6;

    function automatic logic [1:0] nrzi_line(input logic level_j);
        return level_j ? LINE_J : LINE_K;
    endfunction

endpackage

// File: rtl/usb_tx_bitcnt.sv
// Bit position counter within the byte being serialised; wrap_o flags the
// bit 7 position so the encoder knows the next emitted bit closes a byte.
module usb_tx_bitcnt (
    input  logic clk,
    input  logic n_rst,
    input  logic en_i,
    input  logic halt_i,
    input  logic clr_i,
    output logic wrap_o
);
    logic [2:0] cnt_q;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            cnt_q <= 3'd0;
        end else if (clr_i) begin
            cnt_q <= 3'd0;
        end else if (en_i && !halt_i) begin
            cnt_q <= cnt_q + 3'd1;
        end
    end

    assign wrap_o = (cnt_q == 3'd7);

endmodule

// File: rtl/usb_tx_encoder.sv
// USB full-speed transmit encoder: SYNC, LSB-first bytes, bit stuffing, NRZI
// and EOP, all stepped by the 12 MHz bit strobe.
module usb_tx_encoder
    import usb_tx_pkg::*;
#(
    parameter int         STUFF_LEN = STUFF_LEN_DEF,
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       bit_tick,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       tx_data_valid,
    input  logic       tx_last,
    output logic       tx_data_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_busy,
    output logic       tx_done,
    output logic       tx_error
);
    tx_state_e  state_q;
    logic       pending_q;
    logic       busy_q;
    logic       fin_q;
    logic       lvl_j_q;
    logic       ready_q;
    logic       done_q;
    logic       err_q;
    logic [1:0] line_q;
    logic [2:0] stuff_cnt_q;
    logic [7:0] shreg_q;
    logic       last_q;

    logic       active;
    logic       start_tick;
    logic       stuff_now;
    logic       shift_d;
    logic       emit_d;
    logic       wrap;
    logic       boundary_d;
    logic       load_d;
    logic       data_bit_d;
    logic       lvl_j_d;
    logic [2:0] stuff_cnt_d;

    assign active      = (state_q == SYNC) || (state_q == DATA);
    assign start_tick  = bit_tick && (state_q == IDLE) && pending_q;
    assign stuff_now   = active && (stuff_cnt_q == 3'(STUFF_LEN));
    assign shift_d     = bit_tick && active && !stuff_now && !fin_q;
    assign emit_d      = start_tick || shift_d;
    // A byte boundary fetches a new byte unless the byte just finished was the last.
    assign boundary_d  = shift_d && wrap && ((state_q == SYNC) || !last_q);
    assign load_d      = boundary_d && tx_data_valid;
    assign data_bit_d  = start_tick ? SYNC_BYTE[0] : shreg_q[0];
    assign lvl_j_d     = data_bit_d ? lvl_j_q : ~lvl_j_q;
    assign stuff_cnt_d = !data_bit_d ? 3'd0 :
                         start_tick  ? 3'd1 : stuff_cnt_q + 3'd1;

    usb_tx_bitcnt u_bitcnt (
        .clk    (clk),
        .n_rst  (n_rst),
        .en_i   (emit_d),
        .halt_i (stuff_now),
        .clr_i  (!(active || start_tick)),
        .wrap_o (wrap)
    );

    // Payload shift register is data only and carries no reset.
    always_ff @(posedge clk) begin
        if (start_tick) begin
            shreg_q <= SYNC_BYTE >> 1;
        end else if (load_d) begin
            shreg_q <= tx_data;
            last_q  <= tx_last;
        end else if (shift_d) begin
            shreg_q <= shreg_q >> 1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q     <= IDLE;
            pending_q   <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
            lvl_j_q     <= 1'b1;
            line_q      <= LINE_J;
            stuff_cnt_q <= 3'd0;
            ready_q     <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            ready_q <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            if (tx_start && !busy_q) begin
                pending_q <= 1'b1;
                busy_q    <= 1'b1;
            end
            if (emit_d) begin
                lvl_j_q     <= lvl_j_d;
                line_q      <= nrzi_line(lvl_j_d);
                stuff_cnt_q <= stuff_cnt_d;
            end
            if (bit_tick) begin
                case (state_q)
                    IDLE: begin
                        if (pending_q) begin
                            pending_q <= 1'b0;
                            state_q   <= SYNC;
                        end
                    end
                    SYNC, DATA: begin
                        if (stuff_now) begin
                            lvl_j_q     <= ~lvl_j_q;
                            line_q      <= nrzi_line(~lvl_j_q);
                            stuff_cnt_q <= 3'd0;
                        end else if (fin_q) begin
                            fin_q   <= 1'b0;
                            state_q <= EOP1;
                            line_q  <= LINE_SE0;
                        end else if (boundary_d) begin
                            if (tx_data_valid) begin
                                ready_q <= 1'b1;
                                state_q <= DATA;
                            end else begin
                                err_q <= 1'b1;
                                fin_q <= 1'b1;
                            end
                        end else if (wrap) begin
                            fin_q <= 1'b1;
                        end
                    end
                    EOP1: begin
                        state_q <= EOP2;
                        line_q  <= LINE_SE0;
                    end
                    EOP2: begin
                        state_q <= EOP_J;
                        line_q  <= LINE_J;
                        lvl_j_q <= 1'b1;
                    end
                    EOP_J: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign dplus_out     = line_q[1];
    assign dminus_out    = line_q[0];
    assign tx_busy       = busy_q;
    assign tx_done       = done_q;
    assign tx_error      = err_q;
    assign tx_data_ready = ready_q;

endmodule

// File: tb/tb_usb_tx_encoder.sv
// Bench for usb_tx_encoder: per-scenario tasks compare the captured line
// sequence against a bit-level reference built from the packet bytes.
module tb_usb_tx_encoder;
    logic       clk = 1'b0;
    logic       n_rst;
    logic       bit_tick;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       tx_data_valid;
    logic       tx_last;
    logic       tx_data_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_busy;
    logic       tx_done;
    logic       tx_error;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] pkt [8];
    logic [1:0] exp_q [$];
    logic [1:0] rec_q [$];
    int         n_ready;
    int         n_err;
    int         n_done;
    bit         timed_out;
    logic       busy_at_start;

    usb_tx_encoder dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .bit_tick      (bit_tick),
        .tx_start      (tx_start),
        .tx_data       (tx_data),
        .tx_data_valid (tx_data_valid),
        .tx_last       (tx_last),
        .tx_data_ready (tx_data_ready),
        .dplus_out     (dplus_out),
        .dminus_out    (dminus_out),
        .tx_busy       (tx_busy),
        .tx_done       (tx_done),
        .tx_error      (tx_error)
    );

    always #5 clk = ~clk;

    initial begin : tick_gen
        int phase;
        phase    = 0;
        bit_tick = 1'b0;
        forever begin
            @(negedge clk);
            phase++;
            bit_tick = (phase % 4 == 0);
        end
    end

    // Reference: SYNC then bytes LSB first, a 0 after every six 1s, NRZI, SE0 SE0 J.
    task automatic build_exp(input int n);
        logic       lvl;
        int         ones;
        logic [7:0] byt;
        exp_q.delete();
        lvl  = 1'b1;
        ones = 0;
        for (int k = 0; k <= n; k++) begin
            byt = (k == 0) ? 8'h80 : pkt[k-1];
            for (int i = 0; i < 8; i++) begin
                if (!byt[i]) lvl = ~lvl;
                exp_q.push_back(lvl ? 2'b10 : 2'b01);
                ones = byt[i] ? ones + 1 : 0;
                if (ones == 6) begin
                    lvl = ~lvl;
                    exp_q.push_back(lvl ? 2'b10 : 2'b01);
                    ones = 0;
                end
            end
        end
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b00);
        exp_q.push_back(2'b10);
    endtask

    // Sends pkt[0..n-1]; with underrun set the final byte is not flagged last.
    task automatic run_packet(input int n, input bit underrun, input int extra_start);
        int idx;
        idx = 0;
        rec_q.delete();
        n_ready   = 0;
        n_err     = 0;
        n_done    = 0;
        timed_out = 1'b0;
        @(negedge clk);
        tx_data       = pkt[0];
        tx_data_valid = 1'b1;
        tx_last       = (n == 1) && !underrun;
        tx_start      = 1'b1;
        @(posedge clk);
        #1;
        tx_start      = 1'b0;
        busy_at_start = tx_busy;
        for (int c = 0; c < 2000; c++) begin
            tx_start = (c == extra_start);
            @(posedge clk);
            #1;
            if (tx_done) begin
                n_done++;
                break;
            end
            if (bit_tick) rec_q.push_back({dplus_out, dminus_out});
            if (tx_error) n_err++;
            if (tx_data_ready) begin
                n_ready++;
                idx++;
                tx_data_valid = (idx < n);
                tx_data       = (idx < n && idx < 8) ? pkt[idx] : 8'h00;
                tx_last       = (idx == n - 1) && !underrun;
            end
            if (c == 1999) timed_out = 1'b1;
        end
        tx_start      = 1'b0;
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;
    endtask

    task automatic test_reset();
        n_rst         = 1'b0;
        tx_start      = 1'b0;
        tx_data       = 8'h00;
        tx_data_valid = 1'b0;
        tx_last       = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({dplus_out, dminus_out, tx_busy, tx_data_ready, tx_done, tx_error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_hold: dp,dm,busy,ready,done,err got %b expected 100000",
                     {dplus_out, dminus_out, tx_busy, tx_data_ready, tx_done, tx_error});
        end
        @(negedge clk);
        n_rst = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        n_checks++;
        if ({dplus_out, dminus_out, tx_busy, tx_data_ready, tx_done, tx_error} !== 6'b100000) begin
            n_fail++;
            $display("FAIL reset_idle: dp,dm,busy,ready,done,err got %b expected 100000",
                     {dplus_out, dminus_out, tx_busy, tx_data_ready, tx_done, tx_error});
        end
    endtask

    task automatic test_single_byte();
        logic [1:0] gold [19];
        gold = '{2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b01,
                 2'b01, 2'b10, 2'b10, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01,
                 2'b00, 2'b00, 2'b10};
        pkt[0] = 8'hA5;
        run_packet(1, 1'b0, -1);
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL single_timeout: no tx_done within budget, got %0d done pulses expected 1", n_done);
        end
        n_checks++;
        if (busy_at_start !== 1'b1) begin
            n_fail++;
            $display("FAIL single_busy_rise: got %b expected 1", busy_at_start);
        end
        n_checks++;
        if (rec_q.size() !== 19) begin
            n_fail++;
            $display("FAIL single_len: got %0d bit times expected 19", rec_q.size());
        end
        for (int i = 0; i < 19 && i < rec_q.size(); i++) begin
            n_checks++;
            if (rec_q[i] !== gold[i]) begin
                n_fail++;
                $display("FAIL single_bit%0d: line got %b expected %b", i, rec_q[i], gold[i]);
            end
        end
        n_checks++;
        if ({n_ready, n_done, n_err} !== {32'd1, 32'd1, 32'd0}) begin
            n_fail++;
            $display("FAIL single_pulses: ready/done/err got %0d/%0d/%0d expected 1/1/0",
                     n_ready, n_done, n_err);
        end
    endtask

    task automatic test_stuffing();
        int nbytes;
        int want_len;
        for (int t = 0; t < 2; t++) begin
            if (t == 0) begin
                pkt[0] = 8'hFF; pkt[1] = 8'h00; nbytes = 2; want_len = 28;
            end else begin
                pkt[0] = 8'hFC; nbytes = 1; want_len = 20;
            end
            build_exp(nbytes);
            run_packet(nbytes, 1'b0, -1);
            n_checks++;
            if (timed_out !== 1'b0) begin
                n_fail++;
                $display("FAIL stuff%0d_timeout: got no tx_done expected one", t);
            end
            n_checks++;
            if (rec_q.size() !== want_len) begin
                n_fail++;
                $display("FAIL stuff%0d_len: got %0d bit times expected %0d", t, rec_q.size(), want_len);
            end
            for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (rec_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL stuff%0d_bit%0d: line got %b expected %b", t, i, rec_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if (n_ready !== nbytes) begin
                n_fail++;
                $display("FAIL stuff%0d_ready: got %0d pulses expected %0d", t, n_ready, nbytes);
            end
        end
    endtask

    task automatic test_underrun();
        pkt[0] = 8'h12;
        build_exp(1);
        run_packet(1, 1'b1, -1);
        n_checks++;
        if (timed_out !== 1'b0) begin
            n_fail++;
            $display("FAIL underrun_timeout: got no tx_done expected one");
        end
        n_checks++;
        if (rec_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL underrun_len: got %0d bit times expected %0d", rec_q.size(), exp_q.size());
        end
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rec_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL underrun_bit%0d: line got %b expected %b", i, rec_q[i], exp_q[i]);
            end
        end
        n_checks++;
        if ({n_err, n_done, n_ready} !== {32'd1, 32'd1, 32'd1}) begin
            n_fail++;
            $display("FAIL underrun_pulses: err/done/ready got %0d/%0d/%0d expected 1/1/1",
                     n_err, n_done, n_ready);
        end
    endtask

    task automatic test_random();
        int n;
        for (int p = 0; p < 8; p++) begin
            n = $urandom_range(1, 4);
            for (int b = 0; b < n; b++) pkt[b] = 8'($urandom);
            if (p == 0) pkt[0] = 8'hFF;
            build_exp(n);
            repeat ($urandom_range(0, 7)) @(posedge clk);
            run_packet(n, 1'b0, -1);
            n_checks++;
            if (timed_out !== 1'b0 || rec_q.size() !== exp_q.size()) begin
                n_fail++;
                $display("FAIL rand%0d_len: got %0d bit times expected %0d (timeout %0b)",
                         p, rec_q.size(), exp_q.size(), timed_out);
            end
            for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
                n_checks++;
                if (rec_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL rand%0d_bit%0d: line got %b expected %b", p, i, rec_q[i], exp_q[i]);
                end
            end
            n_checks++;
            if ({n_ready, n_err} !== {n, 32'd0}) begin
                n_fail++;
                $display("FAIL rand%0d_pulses: ready/err got %0d/%0d expected %0d/0", p, n_ready, n_err, n);
            end
        end
    endtask

    task automatic test_back_to_back_start();
        int busy_seen;
        int line_moves;
        pkt[0] = 8'h3C;
        pkt[1] = 8'hE1;
        build_exp(2);
        run_packet(2, 1'b0, 30);
        n_checks++;
        if (timed_out !== 1'b0 || rec_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL busy_start_len: got %0d bit times expected %0d", rec_q.size(), exp_q.size());
        end
        for (int i = 0; i < rec_q.size() && i < exp_q.size(); i++) begin
            n_checks++;
            if (rec_q[i] !== exp_q[i]) begin
                n_fail++;
                $display("FAIL busy_start_bit%0d: line got %b expected %b", i, rec_q[i], exp_q[i]);
            end
        end
        busy_seen  = 0;
        line_moves = 0;
        for (int c = 0; c < 80; c++) begin
            @(posedge clk);
            #1;
            if (tx_busy) busy_seen++;
            if ({dplus_out, dminus_out} !== 2'b10) line_moves++;
        end
        n_checks++;
        if (busy_seen !== 0 || line_moves !== 0) begin
            n_fail++;
            $display("FAIL busy_start_second_sync: busy cycles %0d, non-J cycles %0d, expected 0 and 0",
                     busy_seen, line_moves);
        end
    endtask

    task automatic test_reset_mid();
        int pulses;
        @(negedge clk);
        tx_data       = 8'h00;
        tx_data_valid = 1'b1;
        tx_last       = 1'b0;
        tx_start      = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (60) @(posedge clk);
        #1;
        n_checks++;
        if (tx_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_busy_before: got %b expected 1", tx_busy);
        end
        #2;
        n_rst = 1'b0;
        #1;
        n_checks++;
        if ({dplus_out, dminus_out, tx_busy} !== 3'b100) begin
            n_fail++;
            $display("FAIL midreset_line: dp,dm,busy got %b expected 100", {dplus_out, dminus_out, tx_busy});
        end
        tx_data_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_rst  = 1'b1;
        pulses = 0;
        for (int c = 0; c < 60; c++) begin
            @(posedge clk);
            #1;
            if (tx_done || tx_error || tx_busy) pulses++;
        end
        n_checks++;
        if (pulses !== 0) begin
            n_fail++;
            $display("FAIL midreset_after: done/err/busy cycles got %0d expected 0", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_stuffing();
        test_underrun();
        test_random();
        test_back_to_back_start();
        test_reset_mid();
        test_single_byte();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/usb_tx_encoder.md
# usb_tx_encoder

Transmit line encoder for the USB full-speed TX path. It takes packet bytes from the TX byte source under a valid/ready handshake, prepends SYNC, and serialises each byte LSB first. It applies bit stuffing and NRZI encoding, then appends EOP, driving the D+/D− line outputs. All line activity advances only on the 12 MHz bit strobe; the block sits between the TX packet/CRC stage and the pad drivers.

## Interface
- STUFF_LEN, 6: consecutive pre-NRZI ones after which a 0 is inserted.
- SYNC_BYTE, 8'h80: sync pattern, sent LSB first.

- clk  in  1  system clock (48 MHz).
- n_rst  in  1  reset; asynchronous, active-low.
- bit_tick  in  1  one-clk pulse per bit time (every 4th clk).
- tx_start  in  1  one-clk request to begin a packet.
- tx_data  in  8  next packet byte.
- tx_data_valid  in  1  tx_data/tx_last valid.
- tx_last  in  1  accompanying byte is the final byte of the packet.
- tx_data_ready  out  1  one-clk pulse: byte accepted this edge.
- dplus_out  out  1  D+ line level.
- dminus_out  out  1  D− line level.
- tx_busy  out  1  high from accepted tx_start to end of EOP.
- tx_done  out  1  one-clk pulse after EOP J bit completes.
- tx_error  out  1  one-clk pulse on data underrun.

## Operation
- Reset values: dplus_out=1, dminus_out=0 (J); all other outputs 0; state IDLE.
- Line levels: J = (1,0), K = (0,1), SE0 = (0,0).
- States: IDLE, SYNC, DATA, EOP1, EOP2, EOP_J.
- IDLE: tx_start latches a pending flag and raises tx_busy on the next edge. tx_start while tx_busy=1 is ignored.
- At the first bit_tick with pending set, enter SYNC and drive SYNC bit 0. The stuff counter is cleared and the NRZI state is J.
- Bit counter 0..7 tracks position within the current byte. On the bit_tick emitting a byte's bit 7, the counter wraps and the next byte is loaded.
- Byte load at a boundary (after SYNC or after a non-last byte):
  - If tx_data_valid=1: the shift register takes tx_data, the last flag is stored, and tx_data_ready pulses on that same edge. The byte's bit 0 is emitted at the next bit_tick.
  - If tx_data_valid=0: underrun. tx_error pulses and the block enters EOP1, skipping the remaining data.
- After a byte flagged last has emitted bit 7 (plus any pending stuff bit): enter EOP1.
- Bit stuffing:
  - The counter increments on each emitted 1 and clears on each emitted 0 (including stuffed 0s).
  - Counting is continuous across SYNC and data.
  - When the count reaches STUFF_LEN, the next bit_tick emits a stuffed 0 instead of data. The bit counter and shift register hold for that tick.
  - This also applies after the last data bit: the stuff bit precedes EOP.
- NRZI: a 0 toggles J↔K; a 1 holds the current level.
- EOP: EOP1 and EOP2 each drive SE0 for one bit time, EOP_J drives J for one bit time.
- On the bit_tick leaving EOP_J: go to IDLE, clear tx_busy, pulse tx_done.
- Async reset mid-packet: line returns to J immediately; no tx_done or tx_error is produced.

## Timing
- All state, shift, and line changes occur only on clk edges with bit_tick=1. Exceptions: tx_start latch, tx_busy rise, and tx_data_ready timing as specified.
- Outputs are registered; no combinational path from inputs to dplus_out/dminus_out.
- tx_start→first K: the first bit_tick at least one clk after tx_start.
- Packet length in bit times: 8 + 8·N + stuff_bits + 3.
- tx_data_ready is asserted at most once per byte and never outside SYNC/DATA.

## Structure
- Shared package usb_tx_pkg holds:
  - the state enum,
  - J/K/SE0 line constants,
  - SYNC_BYTE default,
  - STUFF_LEN default.
- Sub-module usb_tx_bitcnt: 3-bit counter with enable (bit_tick), halt (stuff), clear, and wrap flag.
- Shift register, stuff counter, NRZI, and FSM live in usb_tx_encoder.

## Test plan
- Reset: hold n_rst=0 → D+=1, D−=0, busy/ready/done/error=0.
- Single byte 8'hA5, last:
  - SYNC line sequence K J K J K J K K.
  - Data sequence K J J K J J K K.
  - Then SE0 SE0 J.
  - 19 bit times, one ready pulse, tx_done once.
- Bytes 8'hFF, 8'h00:
  - Stuffed 0 after the 5th data 1 (SYNC's final 1 counts).
  - 8 + 16 + 1 + 3 = 28 bit times; two ready pulses.
- Last byte 8'hFC: six trailing ones → stuffed 0 emitted, then SE0 SE0 J.
- Underrun: first byte 8'h12 not last, tx_data_valid=0 at the next boundary → tx_error pulse, then SE0 SE0 J, then tx_done.
- Reset asserted mid-DATA → J immediately. tx_start during busy is ignored: no second SYNC.
